// File: rtl/mux_pkg.sv
// Shared encodings and helpers for the stream multiplexer/arbiter family.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A 2-input mux still needs a 1-bit select field.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate the requests so the pointer sits at
// bit 0, take the first set bit, then map that offset back to a channel index.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);

  logic [PW-1:0] base_s;
  logic [N-1:0]  rot_s;
  logic [PW-1:0] off_s;
  logic [PW:0]   sum_s;
  logic [PW:0]   wrap_s;

  // Rotate, find first requester at or after the pointer, un-rotate.
  always_comb begin
    if ({1'b0, ptr_i} < (PW+1)'(N)) begin
      base_s = ptr_i;
    end else begin
      base_s = '0;
    end
    // The doubled vector makes the rotation correct for non-power-of-2 N.
    rot_s = N'({req_i, req_i} >> base_s);
    off_s = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = PW'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, base_s} + {1'b0, off_s};
    if (sum_s >= (PW+1)'(N)) begin
      wrap_s = sum_s - (PW+1)'(N);
    end else begin
      wrap_s = sum_s;
    end
    idx_o = PW'(wrap_s);
    if (|rot_s) begin
      grant_o = {{(N-1){1'b0}}, 1'b1} << idx_o;
    end else begin
      grant_o = '0;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// feeding a single registered output stage.
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 4,
  localparam int SELW     = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] rr_grant_s;
  logic [CHANNELS-1:0] fix_grant_s;
  logic [CHANNELS-1:0] grant_s;
  logic [SELW-1:0]     rr_idx_s;
  logic [SELW-1:0]     grant_idx_s;
  logic                space_s;
  logic                xfer_s;
  logic [WIDTH-1:0]    word_s;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  rr_picker #(
    .N  (CHANNELS),
    .PW (SELW)
  ) u_rr_picker (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant_s),
    .idx_o   (rr_idx_s)
  );

  // Grant selection, handshake and granted-word mux.
  always_comb begin
    fix_grant_s = '0;
    if ({1'b0, sel} < (SELW+1)'(CHANNELS)) begin
      fix_grant_s[sel] = in_valid[sel];
    end else begin
      fix_grant_s = '0;
    end
    case (mode)
      MODE_FIXED: begin
        grant_s     = fix_grant_s;
        grant_idx_s = sel;
      end
      MODE_RR: begin
        grant_s     = rr_grant_s;
        grant_idx_s = rr_idx_s;
      end
      default: begin
        grant_s     = '0;
        grant_idx_s = '0;
      end
    endcase
    space_s  = ~out_valid_q | out_ready;
    in_ready = grant_s & {CHANNELS{space_s & ~reset}};
    xfer_s   = |(in_valid & in_ready);
    // Grant is one-hot or zero, so an AND-OR mux is sufficient.
    word_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      word_s = word_s | ({WIDTH{grant_s[i]}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_data_d  = word_s;
      out_chan_d  = grant_idx_s;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = (grant_idx_s == SELW'(CHANNELS-1)) ? '0 : grant_idx_s + SELW'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed plus randomized bench for stream_mux_arb against a behavioural model.
module tb_stream_mux_arb;

  localparam int W  = 5;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  int checks   = 0;
  int failures = 0;

  int       m_ptr;
  bit       m_valid;
  logic [W-1:0] m_data;
  int       m_chan;

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Which channel the arbitration rules pick this cycle, or -1.
  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic step(input string tag);
    int g;
    bit space;
    logic [CH-1:0] er;
    #1;
    g     = model_grant();
    space = !m_valid || (out_ready === 1'b1);
    er    = '0;
    if (g >= 0 && space && !reset) er[g] = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else if (er != '0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_chan  = g;
      if (mode) m_ptr = (g + 1) % CH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    chk({tag, ".out_chan"},  32'(out_chan),  32'(m_chan));
    @(negedge clk);
  endtask

  initial begin
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = 0;
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    step("rst0");
    step("rst1");
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);

    // Fixed legacy 2:1 behaviour
    reset = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
    in_data = {5'd0, 5'd0, 5'h1F, 5'h00};
    sel = 2'd0; step("fix0");
    chk("fix0.data", 32'(out_data), 32'h00);
    chk("fix0.chan", 32'(out_chan), 32'd0);
    sel = 2'd1; step("fix1");
    chk("fix1.data", 32'(out_data), 32'h1F);
    chk("fix1.chan", 32'(out_chan), 32'd1);

    // Round-robin fairness
    mode = 1'b1;
    in_data = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int k = 0; k < 6; k++) begin
      step("rr");
      chk("rr.seq_chan",  32'(out_chan),  32'(seq[k]));
      chk("rr.seq_valid", 32'(out_valid), 32'd1);
      chk("rr.seq_data",  32'(out_data),  32'(seq[k] + 1));
    end

    // Backpressure holds the word and blocks every input
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("bp");
      chk("bp.hold_data",  32'(out_data),  32'h02);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready",   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'b0100);
    step("bp_rel");
    chk("bp_rel.chan", 32'(out_chan), 32'd2);
    chk("bp_rel.data", 32'(out_data), 32'h03);

    // Skip and wrap of the pointer
    in_valid = 4'b1000; step("wrap0");
    chk("wrap0.chan", 32'(out_chan), 32'd3);
    in_valid = 4'b0100; step("skip");
    chk("skip.chan", 32'(out_chan), 32'd2);
    in_valid = 4'b1010; step("wrap1");
    chk("wrap1.chan", 32'(out_chan), 32'd3);
    step("wrap2");
    chk("wrap2.chan", 32'(out_chan), 32'd1);

    // Fixed select of an idle channel grants nothing
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
    #1;
    chk("nog.in_ready", 32'(in_ready), 32'd0);
    step("nog0");
    chk("nog0.valid", 32'(out_valid), 32'd0);
    step("nog1");
    sel = 2'd0; step("nog_c0");
    chk("nog_c0.data", 32'(out_data), 32'h01);
    sel = 2'd1; step("nog_c1");
    chk("nog_c1.data", 32'(out_data), 32'h02);
    sel = 2'd3; step("nog_c3");
    chk("nog_c3.data", 32'(out_data), 32'h04);

    // Reset in the middle of a round-robin stream
    mode = 1'b1; in_valid = 4'b0010; step("mid0");
    chk("mid0.valid", 32'(out_valid), 32'd1);
    reset = 1'b1; in_valid = 4'hF;
    #1;
    chk("mid.rst_ready", 32'(in_ready), 32'd0);
    step("mid_rst");
    chk("mid_rst.valid", 32'(out_valid), 32'd0);
    chk("mid_rst.data",  32'(out_data),  32'd0);
    chk("mid_rst.chan",  32'(out_chan),  32'd0);
    reset = 1'b0; in_valid = 4'b0110; step("mid_rel");
    chk("mid_rel.chan", 32'(out_chan), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = CH'($urandom);
      in_data   = (CH*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the team's fixed 5-bit 2:1 mux: N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and one registered output stage.
- Two modes: fixed select (legacy 2:1 mux behaviour, generalised to N inputs) or round-robin arbitration.
- Sits between multiple producers (register-file read ports, ALU result sources) and a single downstream consumer.

Parameters:
- WIDTH, 5, data bits per channel.
- CHANNELS, 4, number of input channels (>=2, need not be a power of 2).
- SELW, $clog2(CHANNELS), width of the select/channel-index fields (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: out_valid=0, out_data=0, out_chan=0, rr pointer=0. While reset is high, in_ready is all 0.
- Load condition: space = ~out_valid | out_ready.
- Grant (combinational, one-hot or zero):
  - Fixed mode: grant[sel] = in_valid[sel]. If sel >= CHANNELS, no grant.
  - RR mode: first i with in_valid[i], searching from pointer upward with wrap-around at CHANNELS-1 -> 0.
- in_ready[i] = grant[i] & space & ~reset. Only the granted channel ever sees ready.
- Transfer: when in_valid[g] & in_ready[g], the output register loads in_data[g] and g on the next edge, and sets out_valid=1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready=1 (register drains and refills in the same cycle).
- Drain: out_ready=1 with no transfer clears out_valid on the next edge. out_data and out_chan hold their last values.
- Backpressure: while out_valid & ~out_ready, out_data, out_chan and out_valid stay stable and in_ready is all 0.
- Pointer:
  - RR mode: on each transfer from channel g, pointer <= (g == CHANNELS-1) ? 0 : g+1.
  - Fixed mode: pointer holds.
  - With no transfer, pointer holds.
- Mode/sel changes affect only the arbitration of the current cycle. A word already held in the output register is never modified.
- Reset mid-operation: any held word is discarded, and no transfer completes in the reset cycle.
- Input data is not required to hold while in_ready=0; only the transferred word is captured.

Decomposition:
- Package mux_pkg: a clog2-based select-width helper function and the mode encodings MODE_FIXED=1'b0, MODE_RR=1'b1.
- One combinational sub-module, rr_picker: inputs CHANNELS-bit request vector and pointer; outputs one-hot grant plus index; rotate / find-first / un-rotate implementation.
- The top level holds the output register, pointer and handshake logic.

Test Plan (WIDTH=5, CHANNELS=4):
- Fixed legacy check: mode=0, in_data ch0=00000, ch1=11111, all in_valid=1, out_ready=1.
  - sel=0 -> next cycle out_data=00000, out_chan=0.
  - sel=1 -> out_data=11111, out_chan=1.
- RR fairness: mode=1; ch0..3 = 00001, 00010, 00011, 00100; all valid; out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles, out_valid constant 1.
- Backpressure: out_valid=1 with out_data=00010; out_ready=0 for 3 cycles -> out_data stays 00010, in_ready=0000. Raise out_ready -> in_ready of the granted channel is 1 in the same cycle, and the next word loads on that edge.
- RR skip/wrap:
  - pointer=0, only ch2 valid -> ch2 granted, pointer=3.
  - Then ch1 and ch3 valid -> ch3 granted first, then ch1 (pointer wraps to 0).
- Fixed no-grant: mode=0, sel=2, in_valid=1011 -> in_ready=0000; out_valid falls after current word drains; no data loss on ch0/1/3.
- Reset mid-stream: RR running with pointer=2 and out_valid=1; assert reset 1 cycle -> next cycle out_valid=0, out_data=00000, out_chan=0, pointer=0; in_ready=0000 during reset. After release, first grant goes to the lowest valid channel.
